// File: rtl/ctrl_pkg.sv
// Shared opcode, state and ALU-operation codes for the Mini SRC control sequencer.
package ctrl_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  // Sequencer states; the encoding doubles as the debug step code.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_ROR  = 4'd4,
    ALU_ROL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SHRA = 4'd7,
    ALU_SHL  = 4'd8
  } alu_e;

  // Instruction classes; each class shares one execute-phase microsequence.
  typedef enum logic [2:0] {
    C_RTYPE = 3'd0,
    C_IMM   = 3'd1,
    C_LDI   = 3'd2,
    C_LD    = 3'd3,
    C_ST    = 3'd4,
    C_NOP   = 3'd5,
    C_HALT  = 3'd6,
    C_ILL   = 3'd7
  } cls_e;

endpackage

// File: rtl/ctrl_op_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and the ALU
// operation used in T4. Classes without an ALU step report ADD.
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output cls_e           cls,
  output alu_e           alu
);

  // Class and ALU operation lookup; anything unlisted is illegal.
  always_comb begin
    cls = C_ILL;
    alu = ALU_ADD;
    case (opcode)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  begin cls = C_RTYPE; alu = ALU_ADD;  end
      OP_SUB:  begin cls = C_RTYPE; alu = ALU_SUB;  end
      OP_AND:  begin cls = C_RTYPE; alu = ALU_AND;  end
      OP_OR:   begin cls = C_RTYPE; alu = ALU_OR;   end
      OP_ROR:  begin cls = C_RTYPE; alu = ALU_ROR;  end
      OP_ROL:  begin cls = C_RTYPE; alu = ALU_ROL;  end
      OP_SHR:  begin cls = C_RTYPE; alu = ALU_SHR;  end
      OP_SHRA: begin cls = C_RTYPE; alu = ALU_SHRA; end
      OP_SHL:  begin cls = C_RTYPE; alu = ALU_SHL;  end
      OP_ADDI: begin cls = C_IMM;   alu = ALU_ADD;  end
      OP_ANDI: begin cls = C_IMM;   alu = ALU_AND;  end
      OP_ORI:  begin cls = C_IMM;   alu = ALU_OR;   end
      OP_NOP:  cls = C_NOP;
      OP_HALT: cls = C_HALT;
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Hardwired control sequencer for the Mini SRC datapath.
//
// state | meaning
// IDLE  | after reset, one cycle before the first fetch
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, memory read into MDR; waits for mem_ready
// T2    | MDR -> IR
// T3    | first execute step; nop/illegal return to T0, halt -> HALT
// T4    | ALU operation into Z
// T5    | Z -> register (ALU/ldi) or Z -> MAR (ld/st)
// T6    | ld: memory read (waits); st: register -> MDR
// T7    | ld: MDR -> register; st: memory write (waits)
// HALT  | stopped, all strobes low, left only by reset
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4,
  parameter int TMO  = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            rin,
  output logic            rout,
  output logic            baout,
  output logic            cout,
  output logic            pcout,
  output logic            pcin,
  output logic            incpc,
  output logic            marin,
  output logic            mdrin,
  output logic            mdrout,
  output logic            read,
  output logic            write,
  output logic            irin,
  output logic            yin,
  output logic            zin,
  output logic            zlowout,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal,
  output logic            mem_tmo,
  output logic [3:0]      step
);

  localparam int CW = $clog2(TMO + 2);

  state_e         state, state_n;
  cls_e           cls;
  alu_e           dec_alu, alu_sel;
  logic [OPW-1:0] opcode;
  logic           mem_wait;
  logic           waiting;
  logic [CW-1:0]  wait_cnt;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  ctrl_op_decode #(.OPW(OPW)) u_dec (
    .opcode (opcode),
    .cls    (cls),
    .alu    (dec_alu)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state and strobe decode; everything defaults low.
  always_comb begin
    state_n = state;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; baout = 1'b0;
    cout = 1'b0; pcout = 1'b0; pcin = 1'b0; incpc = 1'b0; marin = 1'b0;
    mdrin = 1'b0; mdrout = 1'b0; read = 1'b0; write = 1'b0; irin = 1'b0;
    yin = 1'b0; zin = 1'b0; zlowout = 1'b0; illegal = 1'b0;
    alu_sel = ALU_ADD;
    case (state)
      S_IDLE: state_n = S_T0;
      S_T0: begin
        pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zin = 1'b1;
        state_n = S_T1;
      end
      S_T1: begin
        zlowout = 1'b1; read = 1'b1; mdrin = 1'b1;
        // PC loads only on the completing cycle so a long wait loads it once
        if (mem_ready) begin
          pcin    = 1'b1;
          state_n = S_T2;
        end
      end
      S_T2: begin
        mdrout = 1'b1; irin = 1'b1;
        state_n = S_T3;
      end
      S_T3: begin
        case (cls)
          C_RTYPE, C_IMM: begin
            grb = 1'b1; rout = 1'b1; yin = 1'b1; state_n = S_T4;
          end
          C_LDI, C_LD, C_ST: begin
            grb = 1'b1; baout = 1'b1; yin = 1'b1; state_n = S_T4;
          end
          C_HALT:  state_n = S_HALT;
          C_ILL: begin
            illegal = 1'b1; state_n = S_T0;
          end
          default: state_n = S_T0;
        endcase
      end
      S_T4: begin
        state_n = S_T0;
        case (cls)
          C_RTYPE: begin
            grc = 1'b1; rout = 1'b1; zin = 1'b1; alu_sel = dec_alu; state_n = S_T5;
          end
          C_IMM, C_LDI, C_LD, C_ST: begin
            cout = 1'b1; zin = 1'b1; alu_sel = dec_alu; state_n = S_T5;
          end
          default: state_n = S_T0;
        endcase
      end
      S_T5: begin
        state_n = S_T0;
        case (cls)
          C_RTYPE, C_IMM, C_LDI: begin
            zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
          end
          C_LD, C_ST: begin
            zlowout = 1'b1; marin = 1'b1; state_n = S_T6;
          end
          default: state_n = S_T0;
        endcase
      end
      S_T6: begin
        state_n = S_T0;
        case (cls)
          C_LD: begin
            read = 1'b1; mdrin = 1'b1;
            state_n = mem_ready ? S_T7 : S_T6;
          end
          C_ST: begin
            gra = 1'b1; rout = 1'b1; mdrin = 1'b1; state_n = S_T7;
          end
          default: state_n = S_T0;
        endcase
      end
      S_T7: begin
        state_n = S_T0;
        case (cls)
          C_LD: begin
            mdrout = 1'b1; gra = 1'b1; rin = 1'b1;
          end
          C_ST: begin
            write = 1'b1;
            state_n = mem_ready ? S_T0 : S_T7;
          end
          default: state_n = S_T0;
        endcase
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  assign alu_op = ALUW'(alu_sel);
  assign run    = (state >= S_T0) && (state <= S_T7);
  assign step   = state;

  assign mem_wait = (state == S_T1) ||
                    ((state == S_T6) && (cls == C_LD)) ||
                    ((state == S_T7) && (cls == C_ST));
  assign waiting  = mem_wait && !mem_ready;

  // Memory-wait counter: counts consecutive stalled cycles, saturates at TMO
  // and sets the sticky timeout flag on the cycle that reaches TMO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      mem_tmo  <= 1'b0;
    end else if (waiting) begin
      if ((TMO != 0) && (wait_cnt != CW'(TMO))) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (wait_cnt == CW'(TMO - 1)) mem_tmo <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: instructions are expanded from the documented
// microsequences into a queue of expected cycles, then replayed against the DUT.
module tb_ctrl_seq;

  localparam int TMO = 15;

  localparam logic [18:0] ZLOWOUT = 19'h00001, ZIN   = 19'h00002, YIN    = 19'h00004;
  localparam logic [18:0] IRIN    = 19'h00008, WRITE = 19'h00010, READ   = 19'h00020;
  localparam logic [18:0] MDROUT  = 19'h00040, MDRIN = 19'h00080, MARIN  = 19'h00100;
  localparam logic [18:0] INCPC   = 19'h00200, PCIN  = 19'h00400, PCOUT  = 19'h00800;
  localparam logic [18:0] COUT    = 19'h01000, BAOUT = 19'h02000, ROUT   = 19'h04000;
  localparam logic [18:0] RIN     = 19'h08000, GRC   = 19'h10000, GRB    = 19'h20000;
  localparam logic [18:0] GRA     = 19'h40000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        mem_ready;
  logic gra, grb, grc, rin, rout, baout, cout, pcout, pcin, incpc, marin;
  logic mdrin, mdrout, read, write, irin, yin, zin, zlowout;
  logic [3:0] alu_op;
  logic run, illegal, mem_tmo;
  logic [3:0] step;

  ctrl_seq #(.OPW(5), .ALUW(4), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .cout(cout), .pcout(pcout), .pcin(pcin), .incpc(incpc), .marin(marin),
    .mdrin(mdrin), .mdrout(mdrout), .read(read), .write(write), .irin(irin),
    .yin(yin), .zin(zin), .zlowout(zlowout), .alu_op(alu_op), .run(run),
    .illegal(illegal), .mem_tmo(mem_tmo), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] m;
    logic [3:0]  alu;
    logic        ill;
    logic        wt;
    logic [31:0] irv;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic tmo_exp;

  wire [29:0] obs = {step, run, illegal, mem_tmo, alu_op,
                     gra, grb, grc, rin, rout, baout, cout, pcout, pcin, incpc,
                     marin, mdrin, mdrout, read, write, irin, yin, zin, zlowout};

  task automatic check(input string tag, input logic [29:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [18:0] m, input logic [3:0] alu,
                      input logic ill, input logic wt, input logic [31:0] irv);
    ent_t e;
    e.st = st; e.m = m; e.alu = alu; e.ill = ill; e.wt = wt; e.irv = irv;
    q.push_back(e);
  endtask

  // Expand one instruction into expected cycles (step code, strobes, alu_op).
  task automatic build(input logic [31:0] irv);
    logic [4:0]  op;
    logic [31:0] junk;
    logic [3:0]  a;
    op   = irv[31:27];
    junk = $urandom;
    push(4'd1, PCOUT | MARIN | INCPC | ZIN, 4'd0, 1'b0, 1'b0, junk);
    push(4'd2, ZLOWOUT | PCIN | READ | MDRIN, 4'd0, 1'b0, 1'b1, junk);
    push(4'd3, MDROUT | IRIN, 4'd0, 1'b0, 1'b0, irv);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(4'd4, GRB | ROUT | YIN, 4'd0, 1'b0, 1'b0, irv);
      push(4'd5, GRC | ROUT | ZIN, 4'(op - 5'd3), 1'b0, 1'b0, irv);
      push(4'd6, ZLOWOUT | GRA | RIN, 4'd0, 1'b0, 1'b0, irv);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      a = (op == 5'd12) ? 4'd0 : (op == 5'd13) ? 4'd2 : 4'd3;
      push(4'd4, GRB | ROUT | YIN, 4'd0, 1'b0, 1'b0, irv);
      push(4'd5, COUT | ZIN, a, 1'b0, 1'b0, irv);
      push(4'd6, ZLOWOUT | GRA | RIN, 4'd0, 1'b0, 1'b0, irv);
    end else if (op <= 5'd2) begin
      push(4'd4, GRB | BAOUT | YIN, 4'd0, 1'b0, 1'b0, irv);
      push(4'd5, COUT | ZIN, 4'd0, 1'b0, 1'b0, irv);
      if (op == 5'd1) begin
        push(4'd6, ZLOWOUT | GRA | RIN, 4'd0, 1'b0, 1'b0, irv);
      end else begin
        push(4'd6, ZLOWOUT | MARIN, 4'd0, 1'b0, 1'b0, irv);
        if (op == 5'd0) begin
          push(4'd7, READ | MDRIN, 4'd0, 1'b0, 1'b1, irv);
          push(4'd8, MDROUT | GRA | RIN, 4'd0, 1'b0, 1'b0, irv);
        end else begin
          push(4'd7, GRA | ROUT | MDRIN, 4'd0, 1'b0, 1'b0, irv);
          push(4'd8, WRITE, 4'd0, 1'b0, 1'b1, irv);
        end
      end
    end else if (op == 5'd27) begin
      push(4'd4, 19'd0, 4'd0, 1'b0, 1'b0, irv);
      for (int i = 0; i < 50; i++) push(4'd9, 19'd0, 4'd0, 1'b0, 1'b0, irv);
    end else begin
      push(4'd4, 19'd0, 4'd0, (op != 5'd26), 1'b0, irv);
    end
  endtask

  task automatic cyc(input ent_t e, input logic mr, input logic [18:0] m, input string tag);
    ir = e.irv;
    mem_ready = mr;
    #1;
    check(tag, {e.st, (e.st >= 4'd1 && e.st <= 4'd8), e.ill, tmo_exp, e.alu, m});
    @(posedge clk);
    #1;
  endtask

  // Replay the queue. w1/wm: wait cycles for fetch / data phase (-1 = random).
  // stuck: the data-phase wait never completes and the queue is abandoned.
  task automatic run_q(input int w1, input int wm, input bit stuck);
    ent_t e;
    int   w;
    int   cnt;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.wt) begin
        if (e.st >= 4'd7) w = (wm >= 0) ? wm : int'($urandom_range(0, 4));
        else              w = (w1 >= 0) ? w1 : int'($urandom_range(0, 4));
        cnt = 0;
        for (int i = 0; i < w; i++) begin
          cyc(e, 1'b0, e.m & ~PCIN, $sformatf("wait_step%0d_%0d", e.st, i));
          cnt++;
          if (TMO != 0 && cnt >= TMO) tmo_exp = 1'b1;
        end
        if (stuck && e.st >= 4'd7) begin
          q.delete();
          return;
        end
        cyc(e, 1'b1, e.m, $sformatf("done_step%0d", e.st));
      end else begin
        cyc(e, 1'($urandom), e.m, $sformatf("step%0d", e.st));
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    tmo_exp = 1'b0;
    check("reset_async", 30'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    reset_n   = 1'b1;
    #1;
    check("idle", 30'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] irv;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    ir        = 32'd0;
    tmo_exp   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    build(32'h18000000);                 // add, no fetch wait
    run_q(0, 0, 1'b0);
    build({5'b00000, 27'h0123456});      // ld, 3 stalled cycles in T6
    run_q(0, 3, 1'b0);
    build({5'b10111, 27'h0});            // unsupported opcode
    run_q(-1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      irv = {op, 27'($urandom)};
      build(irv);
      run_q(-1, -1, 1'b0);
    end

    build({5'b00010, 27'h0000042});      // st with memory stuck in T7
    run_q(0, 20, 1'b1);
    do_reset();                          // async clear mid-write

    build({5'b11011, 27'h0});            // halt
    run_q(-1, -1, 1'b0);
    do_reset();

    build({5'b00110, 27'h0});            // or, after halt recovery
    build({5'b11010, 27'h0});            // nop
    run_q(-1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
